// File: rtl/fetch_unit_if.sv
// Bundles fetch_unit's instruction-memory read port, redirect inputs and decode handshake.
// The master modport is the fetch stage's view; the slave modport is the surrounding pipeline.
interface fetch_unit_if #(
    parameter int NBITS     = 32,
    parameter int NBITSJUMP = 26,
    parameter int INBITS    = 16
);
    logic                 o_imem_req;
    logic [NBITS-1:0]     o_imem_addr;
    logic [NBITS-1:0]     i_imem_data;

    logic                 i_branch_taken;
    logic [INBITS-1:0]    i_branch_offset;
    logic                 i_jump;
    logic [NBITSJUMP-1:0] i_jump_index;
    logic [NBITS-1:0]     i_redir_pc4;

    // Decode handshake: the head entry (o_instr/o_pc4) transfers on every cycle where
    // o_valid && i_ready; o_valid only drops without a transfer on a redirect or reset.
    logic                 o_valid;
    logic [NBITS-1:0]     o_instr;
    logic [NBITS-1:0]     o_pc4;
    logic                 i_ready;

    modport master (
        output o_imem_req, o_imem_addr, o_valid, o_instr, o_pc4,
        input  i_imem_data, i_branch_taken, i_branch_offset, i_jump,
               i_jump_index, i_redir_pc4, i_ready
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_valid, o_instr, o_pc4,
        output i_imem_data, i_branch_taken, i_branch_offset, i_jump,
               i_jump_index, i_redir_pc4, i_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle-latency imem reads and buffers responses
// in a DEPTH-entry prefetch queue. Define FETCH_BYPASS_EN to present a response to an empty queue same-cycle.
module fetch_unit #(
    parameter int               NBITS     = 32,
    parameter int               NBITSJUMP = 26,
    parameter int               INBITS    = 16,
    parameter int               DEPTH     = 4,
    parameter logic [NBITS-1:0] RESET_PC  = '0
) (
    input logic           i_clk,
    input logic           i_reset,
    fetch_unit_if.master  io_bus
);
    localparam int               PW       = $clog2(DEPTH);
    localparam int               CW       = PW + 1;
    localparam logic [CW:0]      DEPTH_W  = (CW+1)'(DEPTH);
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [NBITS-1:0] PC_STEP  = NBITS'(4);

    logic [NBITS-1:0] r_fetch_pc;
    logic [NBITS-1:0] r_req_pc4;
    logic             r_inflight;
    logic [NBITS-1:0] r_q_instr [DEPTH];
    logic [NBITS-1:0] r_q_pc4   [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic             w_redirect;
    logic             w_credit_ok;
    logic             w_req;
    logic             w_resp_live;
    logic             w_q_empty;
    logic             w_bypass;
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_q_pop;
    logic [NBITS-1:0] w_offset_sext;
    logic [NBITS-1:0] w_branch_target;
    logic [NBITS-1:0] w_jump_target;
    logic [NBITS-1:0] w_target;

    assign w_redirect = io_bus.i_branch_taken | io_bus.i_jump;

    // Credit counts the in-flight response so a full queue can never be overrun.
    assign w_credit_ok = ({1'b0, r_count} + {{CW{1'b0}}, r_inflight}) < DEPTH_W;
    assign w_req       = !i_reset && !w_redirect && w_credit_ok;

    assign w_resp_live = r_inflight && !w_redirect && !i_reset;
    assign w_q_empty   = (r_count == '0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_q_empty && w_resp_live;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_valid = (!w_q_empty || w_bypass) && !w_redirect && !i_reset;
    assign w_pop   = w_valid && io_bus.i_ready;
    // A bypassed response that decode accepts is consumed without touching the queue.
    assign w_push  = w_resp_live && !(w_bypass && io_bus.i_ready);
    assign w_q_pop = w_pop && !w_bypass;

    assign w_offset_sext   = {{(NBITS-INBITS){io_bus.i_branch_offset[INBITS-1]}},
                              io_bus.i_branch_offset};
    assign w_branch_target = io_bus.i_redir_pc4 + (w_offset_sext << 2);
    assign w_jump_target   = {io_bus.i_redir_pc4[NBITS-1:NBITSJUMP+2],
                              io_bus.i_jump_index, 2'b00};
    assign w_target        = io_bus.i_jump ? w_jump_target : w_branch_target;

    assign io_bus.o_imem_req  = w_req;
    assign io_bus.o_imem_addr = r_fetch_pc;
    assign io_bus.o_valid     = w_valid;
    assign io_bus.o_instr     = w_bypass ? io_bus.i_imem_data : r_q_instr[r_rd_ptr];
    assign io_bus.o_pc4       = w_bypass ? r_req_pc4          : r_q_pc4[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc4  <= '0;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (w_redirect) begin
            // No request is issued this cycle, so clearing inflight drops every older response.
            r_fetch_pc <= w_target;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_req) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
                r_req_pc4  <= r_fetch_pc + PC_STEP;
                r_inflight <= 1'b1;
            end else begin
                r_inflight <= 1'b0;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_q_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_q_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= io_bus.i_imem_data;
            r_q_pc4[r_wr_ptr]   <= r_req_pc4;
        end
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage that succeeds the single-cycle PC / PC+4 adder / branch mux / jump mux path. It owns the PC and issues requests to a synchronous instruction memory with 1-cycle read latency. Returned instructions are buffered with their PC+4 in a DEPTH-entry prefetch queue and handed to decode over a valid/ready handshake. Branch and jump redirects arrive from later stages and flush all wrong-path state.

Parameters:
NBITS, 32, instruction/PC width
NBITSJUMP, 26, jump index width
INBITS, 16, branch offset width (sign-extended internally)
DEPTH, 4, prefetch queue entries; power of 2, >=2
RESET_PC, 0, PC value after reset

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
o_imem_req  out  1  read request this cycle
o_imem_addr  out  NBITS  read address; bits[1:0] always 0
i_imem_data  in  NBITS  instruction; valid the cycle after a request
i_branch_taken  in  1  branch redirect (one-cycle pulse)
i_branch_offset  in  INBITS  word offset for branch
i_jump  in  1  jump redirect (one-cycle pulse)
i_jump_index  in  NBITSJUMP  jump index field
i_redir_pc4  in  NBITS  PC+4 of the redirecting instruction
o_valid  out  1  queue head valid
o_instr  out  NBITS  head instruction
o_pc4  out  NBITS  head PC+4
i_ready  in  1  decode accepts head

Behaviour:
- Reset (sync, i_reset=1 at posedge):
  - fetch_pc=RESET_PC, queue empty, inflight=0.
  - o_valid=0 and o_imem_req=0 while i_reset is high.
- Request issue: o_imem_req = !i_reset && !redirect && (count+inflight < DEPTH).
  - Uses registered values only.
  - o_imem_addr = fetch_pc.
  - On request: fetch_pc <= fetch_pc+4, wrapping mod 2^NBITS.
  - inflight <= 1, and the request's PC+4 is latched.
- Response: in the cycle after a request, i_imem_data and the latched PC+4 are pushed at the tail, unless killed by a redirect.
- Output: o_valid = (count!=0) && !redirect. o_instr/o_pc4 come from the head. A pop occurs when o_valid && i_ready.
- Simultaneous push and pop: count is unchanged; works at full and at empty (empty case only under the bypass feature).
- Credit rule: count never exceeds DEPTH, so there is no overflow. The ptr wrap is modulo DEPTH.
- redirect = i_branch_taken | i_jump.
  - Jump has priority if both are asserted.
  - Jump target = {i_redir_pc4[NBITS-1:NBITSJUMP+2], i_jump_index, 2'b00}.
  - Branch target = i_redir_pc4 + (sext(i_branch_offset) << 2), wrapping.
- Redirect in cycle t:
  - o_valid=0 and o_imem_req=0 in t.
  - At the end of t: queue emptied, fetch_pc <= target.
  - Any response arriving in t+1 from a request issued at or before t is discarded.
  - First request at t+1 to the target.
- Latency without bypass: request at t, o_valid at t+2.
- Redirect during reset: reset wins.
- Reset mid-stream: the queue and inflight response are dropped identically to a flush; PC returns to RESET_PC.
- Back-to-back redirects: each cycle's redirect overrides the previous one. Only the last target is fetched.

Optional Feature:
FETCH_BYPASS_EN:
- Defined: when the queue is empty and a non-killed response arrives, it is presented combinationally the same cycle.
  - o_valid=1, o_instr=i_imem_data, o_pc4=latched PC+4.
  - If i_ready=1 it is consumed without being written. Otherwise it is enqueued.
  - Latency: request at t, o_valid at t+1.
- Undefined: all responses pass through the queue, giving 2-cycle latency. This is the default.

Test Plan:
- Reset release, RESET_PC=0, i_ready=1, imem returns addr-based words:
  - req addrs 0,4,8,… on consecutive cycles.
  - First o_valid 2 cycles after first req (1 with FETCH_BYPASS_EN); o_pc4=4,8,12.
- i_ready=0 held:
  - exactly DEPTH=4 requests are issued (addrs 0..12), then o_imem_req=0.
  - count stays 4; raising i_ready for 1 cycle allows exactly 1 new req (addr 16).
- Branch with i_redir_pc4=0x20, i_branch_offset=0xFFFE:
  - target 0x18; o_valid=0 that cycle; queue flushed.
  - The next-cycle response is dropped; first new req addr 0x18.
- Jump with i_redir_pc4=0xA0000010, i_jump_index=0x0000040:
  - target 0xA0000100.
  - With i_branch_taken asserted simultaneously, the jump target still wins.
- fetch_pc=0xFFFFFFFC request: next req addr 0x00000000; o_pc4 for that word = 0.
- i_reset asserted with 3 queued entries and 1 inflight:
  - next cycle o_valid=0, o_imem_req=0.
  - After release the first req addr = RESET_PC; the stale response is never output.
